ifetch: RTL and testbench

Instruction fetch unit feeding the decoder. It owns the architectural fetch PC and reads each 32-bit instruction as four little-endian bytes from the byte-wide memory controller port. It holds the assembled instruction until the decoder consumes it, and redirects on decoder branch/jump targets or ROB flushes, discarding any partial fetch.

---
 rtl/ifetch_pkg.sv | 19 +
 rtl/ifetch.sv | 132 +++++++++++++
 tb/tb_ifetch.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// default reset PC and byte-address helper.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_HOLD  = 2'd2,
    IF_HALT  = 2'd3
  } if_state_e;

  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

  // Address of byte idx of the instruction at base; wraps modulo 2^32.
  function automatic logic [31:0] if_byte_addr(input logic [31:0] base, input logic [1:0] idx);
    return base + {30'd0, idx};
  endfunction

endpackage

// File: rtl/ifetch.sv
// Instruction fetch unit: reads each 32-bit instruction as four
// little-endian bytes, holds it until the decoder consumes it, and
// restarts on decoder redirects or ROB flushes.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [7:0]  mem_data,
  output logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        need_inst,
  input  logic        dec_redirect,
  input  logic [31:0] dec_redirect_addr,
  input  logic        dec_halt,
  input  logic        rob_flush,
  input  logic [31:0] rob_flush_pc
);

  if_state_e   r_state;
  logic [31:0] r_pc;
  logic [1:0]  r_cnt;
  logic [23:0] r_buf;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic        r_inst_ready;
  logic [31:0] r_inst_out;
  logic [31:0] r_inst_pc;

  // A byte is accepted only when nothing redirects the fetch this cycle.
  logic w_capture;
  assign w_capture = rdy && !rob_flush && !dec_redirect && !dec_halt &&
                     (r_state == IF_FETCH) && mem_ready;

  // Collect the three low bytes; the top byte goes straight into inst_out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf <= '0;
    end else if (w_capture) begin
      case (r_cnt)
        2'd0:    r_buf[7:0]   <= mem_data;
        2'd1:    r_buf[15:8]  <= mem_data;
        2'd2:    r_buf[23:16] <= mem_data;
        default: ;
      endcase
    end
  end

  // Fetch sequencing, redirect priority and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IF_IDLE;
      r_pc         <= RESET_PC;
      r_cnt        <= 2'd0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_inst_ready <= 1'b0;
      r_inst_out   <= 32'd0;
      r_inst_pc    <= 32'd0;
    end else if (rdy) begin
      if (rob_flush) begin
        r_pc         <= rob_flush_pc;
        r_state      <= IF_IDLE;
        r_cnt        <= 2'd0;
        r_mem_req    <= 1'b0;
        r_inst_ready <= 1'b0;
      end else if (r_state == IF_HALT) begin
        // Parked until a flush; decoder redirects and halts are ignored.
      end else if (dec_redirect) begin
        r_pc         <= dec_redirect_addr;
        r_state      <= IF_IDLE;
        r_cnt        <= 2'd0;
        r_mem_req    <= 1'b0;
        r_inst_ready <= 1'b0;
      end else if (dec_halt) begin
        r_state      <= IF_HALT;
        r_cnt        <= 2'd0;
        r_mem_req    <= 1'b0;
        r_inst_ready <= 1'b0;
      end else begin
        case (r_state)
          IF_IDLE: begin
            r_state    <= IF_FETCH;
            r_cnt      <= 2'd0;
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_pc;
          end
          IF_FETCH: begin
            if (mem_ready) begin
              if (r_cnt == 2'd3) begin
                r_inst_out   <= {mem_data, r_buf};
                r_inst_pc    <= r_pc;
                r_inst_ready <= 1'b1;
                r_mem_req    <= 1'b0;
                r_cnt        <= 2'd0;
                r_state      <= IF_HOLD;
              end else begin
                r_cnt      <= r_cnt + 2'd1;
                r_mem_addr <= if_byte_addr(r_pc, r_cnt + 2'd1);
              end
            end
          end
          IF_HOLD: begin
            if (!need_inst) begin
              r_inst_ready <= 1'b0;
              r_pc         <= r_pc + 32'd4;
              r_cnt        <= 2'd0;
              r_state      <= IF_FETCH;
              r_mem_req    <= 1'b1;
              r_mem_addr   <= r_pc + 32'd4;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign inst_ready = r_inst_ready;
  assign inst_out   = r_inst_out;
  assign inst_pc    = r_inst_pc;

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed scenarios followed by a randomized run checked
// against a PC-sequence reference model and a byte-addressed memory image.
`timescale 1ns/1ps
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        mem_ready = 1'b0;
  logic [7:0]  mem_data = 8'd0;
  logic        need_inst = 1'b1;
  logic        dec_redirect = 1'b0;
  logic [31:0] dec_redirect_addr = 32'd0;
  logic        dec_halt = 1'b0;
  logic        rob_flush = 1'b0;
  logic [31:0] rob_flush_pc = 32'd0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_pc;
  logic        halted;
  logic [31:0] diff;

  always #5 clk = ~clk;

  ifetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .rst              (rst),
    .rdy              (rdy),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_ready        (mem_ready),
    .mem_data         (mem_data),
    .inst_ready       (inst_ready),
    .inst_out         (inst_out),
    .inst_pc          (inst_pc),
    .need_inst        (need_inst),
    .dec_redirect     (dec_redirect),
    .dec_redirect_addr(dec_redirect_addr),
    .dec_halt         (dec_halt),
    .rob_flush        (rob_flush),
    .rob_flush_pc     (rob_flush_pc)
  );

  // Memory image: a fixed program word at 0..3, a hash elsewhere.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] b;
    case (a)
      32'd0:   b = 8'h13;
      32'd1:   b = 8'h05;
      32'd2:   b = 8'h10;
      32'd3:   b = 8'h00;
      default: b = (a[7:0] * 8'd7) ^ a[15:8] ^ a[31:24] ^ 8'h3C;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge and the
  // memory answers for whatever address is now presented.
  task automatic cycle();
    @(posedge clk);
    #1;
    mem_data = mem_byte(mem_addr);
  endtask

  task automatic wait_inst(input string tag, input logic [31:0] pc);
    int k = 0;
    while (!inst_ready && k < 50) begin
      cycle();
      k++;
    end
    chk({tag, "_rdy"}, 32'(inst_ready), 32'd1);
    chk({tag, "_pc"}, inst_pc, pc);
    chk({tag, "_data"}, inst_out, mem_word(pc));
    $display("inst %s pc=%h data=%h", tag, inst_pc, inst_out);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and first fetch latency.
    rst = 1'b0; rdy = 1'b1; mem_ready = 1'b1; need_inst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_ready", 32'(inst_ready), 32'd0);
    chk("rst_out", inst_out, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    rst = 1'b1;
    mem_data = mem_byte(mem_addr);
    for (int k = 1; k <= 5; k++) begin
      cycle();
      if (k < 5) chk("t1_busy", 32'(inst_ready), 32'd0);
      if (k == 1) begin
        chk("t1_req", 32'(mem_req), 32'd1);
        chk("t1_addr0", mem_addr, 32'd0);
      end
      if (k == 2) chk("t1_addr1", mem_addr, 32'd1);
    end
    chk("t1_ready", 32'(inst_ready), 32'd1);
    chk("t1_out", inst_out, 32'h0010_0513);
    chk("t1_pc", inst_pc, 32'd0);
    $display("inst t1 pc=%h data=%h", inst_pc, inst_out);
    cycle();
    chk("t1_next_req", 32'(mem_req), 32'd1);
    chk("t1_next_addr", mem_addr, 32'd4);
    chk("t1_consumed", 32'(inst_ready), 32'd0);
    need_inst = 1'b1;

    // Decoder stall: instruction held, no requests.
    wait_inst("t2", 32'd4);
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("t2_hold_rdy", 32'(inst_ready), 32'd1);
      chk("t2_hold_req", 32'(mem_req), 32'd0);
      chk("t2_hold_pc", inst_pc, 32'd4);
      chk("t2_hold_out", inst_out, mem_word(32'd4));
    end
    need_inst = 1'b0;
    cycle();
    need_inst = 1'b1;
    chk("t2_consume_rdy", 32'(inst_ready), 32'd0);
    chk("t2_consume_addr", mem_addr, 32'd8);
    chk("t2_consume_req", 32'(mem_req), 32'd1);

    // Redirect after two bytes of the fetch at 8.
    cycle();
    cycle();
    chk("t3_partial_addr", mem_addr, 32'd10);
    dec_redirect = 1'b1; dec_redirect_addr = 32'h100;
    cycle();
    dec_redirect = 1'b0;
    chk("t3_idle_req", 32'(mem_req), 32'd0);
    cycle();
    chk("t3_req", 32'(mem_req), 32'd1);
    chk("t3_addr", mem_addr, 32'h100);
    wait_inst("t3", 32'h100);

    // Halt, redirect ignored while halted, flush resumes.
    dec_halt = 1'b1;
    cycle();
    dec_halt = 1'b0;
    chk("t4_halt_rdy", 32'(inst_ready), 32'd0);
    for (int k = 0; k < 20; k++) begin
      if (k == 5) begin
        dec_redirect = 1'b1; dec_redirect_addr = 32'h300;
      end
      cycle();
      dec_redirect = 1'b0;
      chk("t4_halt_req", 32'(mem_req), 32'd0);
      chk("t4_halt_ready", 32'(inst_ready), 32'd0);
    end
    rob_flush = 1'b1; rob_flush_pc = 32'h40;
    cycle();
    rob_flush = 1'b0;
    chk("t4_idle_req", 32'(mem_req), 32'd0);
    cycle();
    chk("t4_req", 32'(mem_req), 32'd1);
    chk("t4_addr", mem_addr, 32'h40);
    wait_inst("t4", 32'h40);

    // Flush beats a simultaneous decoder redirect.
    rob_flush = 1'b1; rob_flush_pc = 32'h80;
    dec_redirect = 1'b1; dec_redirect_addr = 32'h200;
    cycle();
    rob_flush = 1'b0; dec_redirect = 1'b0;
    cycle();
    chk("t5_addr", mem_addr, 32'h80);
    wait_inst("t5", 32'h80);

    // Consume and redirect in the same HOLD cycle: target wins over pc+4.
    need_inst = 1'b0; dec_redirect = 1'b1; dec_redirect_addr = 32'h180;
    cycle();
    need_inst = 1'b1; dec_redirect = 1'b0;
    chk("t5b_rdy", 32'(inst_ready), 32'd0);
    cycle();
    chk("t5b_addr", mem_addr, 32'h180);
    wait_inst("t5b", 32'h180);

    // Address wrap across 2^32.
    dec_redirect = 1'b1; dec_redirect_addr = 32'hFFFF_FFFE;
    cycle();
    dec_redirect = 1'b0;
    cycle();
    chk("wrap_a0", mem_addr, 32'hFFFF_FFFE);
    cycle();
    chk("wrap_a1", mem_addr, 32'hFFFF_FFFF);
    cycle();
    chk("wrap_a2", mem_addr, 32'h0000_0000);
    cycle();
    chk("wrap_a3", mem_addr, 32'h0000_0001);
    wait_inst("wrap", 32'hFFFF_FFFE);
    need_inst = 1'b0;
    cycle();
    need_inst = 1'b1;
    chk("wrap_next", mem_addr, 32'h0000_0002);

    // rdy=0 freeze in the middle of byte 2.
    cycle();
    cycle();
    chk("t6_mid_addr", mem_addr, 32'd4);
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mem_ready = ~mem_ready;
      cycle();
      chk("t6_frz_addr", mem_addr, 32'd4);
      chk("t6_frz_req", 32'(mem_req), 32'd1);
      chk("t6_frz_rdy", 32'(inst_ready), 32'd0);
    end
    rdy = 1'b1; mem_ready = 1'b1;
    cycle();
    chk("t6_res_rdy", 32'(inst_ready), 32'd0);
    chk("t6_res_addr", mem_addr, 32'd5);
    cycle();
    chk("t6_done_rdy", 32'(inst_ready), 32'd1);
    chk("t6_done_pc", inst_pc, 32'd2);
    chk("t6_done_out", inst_out, mem_word(32'd2));

    // Asynchronous reset in the middle of a fetch.
    need_inst = 1'b0;
    cycle();
    need_inst = 1'b1;
    cycle();
    #2;
    rst = 1'b0;
    #1;
    chk("t6r_req", 32'(mem_req), 32'd0);
    chk("t6r_addr", mem_addr, 32'd0);
    chk("t6r_ready", 32'(inst_ready), 32'd0);
    chk("t6r_out", inst_out, 32'd0);
    chk("t6r_pc", inst_pc, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    mem_data = mem_byte(mem_addr);
    cycle();
    chk("t6r_restart_req", 32'(mem_req), 32'd1);
    chk("t6r_restart_addr", mem_addr, 32'd0);
    wait_inst("t6r", 32'd0);

    // Randomized run against the PC-sequence model.
    rob_flush = 1'b1; rob_flush_pc = 32'h1000;
    cycle();
    rob_flush = 1'b0;
    exp_pc = 32'h1000;
    halted = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (halted) begin
        chk("r_halt_req", 32'(mem_req), 32'd0);
        chk("r_halt_rdy", 32'(inst_ready), 32'd0);
      end else begin
        if (inst_ready) begin
          chk("r_pc", inst_pc, exp_pc);
          chk("r_data", inst_out, mem_word(exp_pc));
        end
        if (mem_req) begin
          diff = mem_addr - exp_pc;
          chk("r_addr_win", 32'(diff < 32'd4), 32'd1);
        end
      end
      rdy               = ($urandom_range(7) != 0);
      mem_ready         = ($urandom_range(3) != 0);
      if (!mem_ready) mem_data = 8'($urandom);
      need_inst         = ($urandom_range(2) == 0);
      rob_flush         = ($urandom_range(39) == 0) || (halted && ($urandom_range(7) == 0));
      rob_flush_pc      = $urandom;
      dec_redirect      = ($urandom_range(29) == 0);
      dec_redirect_addr = $urandom;
      dec_halt          = ($urandom_range(59) == 0);
      if (rdy) begin
        if (rob_flush) begin
          exp_pc = rob_flush_pc;
          halted = 1'b0;
        end else if (!halted) begin
          if (dec_redirect) exp_pc = dec_redirect_addr;
          else if (dec_halt) halted = 1'b1;
          else if (inst_ready && !need_inst) exp_pc = exp_pc + 32'd4;
        end
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
